// File: rtl/bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : bus_arbiter                                            |
// | Description : Two-requester round-robin arbiter driving a single     |
// |               external bus. Each access holds cs for WAIT_CYCLES+1   |
// |               cycles, then pulses the owner's ack for one cycle.     |
// |               All outputs are registered (Moore).                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bus_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        wr_rd0,
  input  logic        wr_rd1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  input  logic [31:0] data_bus_read,
  output logic [31:0] addr,
  output logic [31:0] data_bus_write,
  output logic        cs,
  output logic        wr_rd
);

  // Counter is 4 bits wide, enough for the 0..15 wait range.
  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic        r_last_grant;   // requester that won the previous grant
  logic        r_owner;        // requester owning the access in flight

  logic        w_any_req;
  logic        w_pick1;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_wr_rd;

  // Round-robin choice: a lone requester wins; on a tie the requester
  // that did not win last time is picked.
  always_comb begin
    w_any_req   = req0 | req1;
    w_pick1     = req1 & (~req0 | ~r_last_grant);
    w_sel_addr  = w_pick1 ? addr1  : addr0;
    w_sel_wdata = w_pick1 ? wdata1 : wdata0;
    w_sel_wr_rd = w_pick1 ? wr_rd1 : wr_rd0;
  end

  // Access sequencer: grant in IDLE, hold the bus through ACCESS, ack in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_count        <= 4'd0;
      r_last_grant   <= 1'b1;   // requester 0 wins the first tie
      r_owner        <= 1'b0;
      cs             <= 1'b0;
      wr_rd          <= 1'b0;
      addr           <= 32'd0;
      data_bus_write <= 32'd0;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata          <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          cs   <= 1'b0;
          if (w_any_req) begin
            // Latch the winner's request so later input changes are ignored.
            r_owner        <= w_pick1;
            r_last_grant   <= w_pick1;
            addr           <= w_sel_addr;
            data_bus_write <= w_sel_wdata;
            wr_rd          <= w_sel_wr_rd;
            r_count        <= c_wait;
            cs             <= 1'b1;
            r_state        <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            // Last bus cycle: release cs, raise the owner's ack, and
            // capture read data while the device is still selected.
            cs      <= 1'b0;
            ack0    <= ~r_owner;
            ack1    <= r_owner;
            if (!wr_rd) begin
              rdata <= data_bus_read;
            end
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          cs      <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          cs      <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_bus_arbiter                                         |
// | Description : Self-checking bench for bus_arbiter. Two instances     |
// |               (WAIT_CYCLES=2 and 0) share stimulus and are compared  |
// |               every cycle against a transaction-timing model.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr_rd0, wr_rd1;
  logic [31:0] addr0, addr1, wdata0, wdata1, data_bus_read;

  logic [1:0]  ack0_o, ack1_o, cs_o, wr_o;
  logic [31:0] rdata_o [2];
  logic [31:0] addr_o  [2];
  logic [31:0] dbw_o   [2];

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wr_rd0(wr_rd0), .wr_rd1(wr_rd1), .ack0(ack0_o[0]), .ack1(ack1_o[0]),
    .rdata(rdata_o[0]), .data_bus_read(data_bus_read), .addr(addr_o[0]),
    .data_bus_write(dbw_o[0]), .cs(cs_o[0]), .wr_rd(wr_o[0])
  );

  bus_arbiter #(.WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .wr_rd0(wr_rd0), .wr_rd1(wr_rd1), .ack0(ack0_o[1]), .ack1(ack1_o[1]),
    .rdata(rdata_o[1]), .data_bus_read(data_bus_read), .addr(addr_o[1]),
    .data_bus_write(dbw_o[1]), .cs(cs_o[1]), .wr_rd(wr_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each access is described by its grant edge g: cs is high after edges
  // g..g+W, ack after edge g+W+1, and the bus is free again after g+W+2.
  int          c_w [2] = '{2, 0};
  int          cyc = 0;
  bit          m_act  [2];
  int          m_g    [2];
  bit          m_own  [2];
  bit          m_last [2];
  bit          m_wr   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_dbw  [2];
  logic [31:0] m_rd   [2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k]  = 1'b0;
      m_g[k]    = 0;
      m_own[k]  = 1'b0;
      m_last[k] = 1'b1;
      m_wr[k]   = 1'b0;
      m_addr[k] = 32'd0;
      m_dbw[k]  = 32'd0;
      m_rd[k]   = 32'd0;
    end
  endfunction

  function automatic void m_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_act[k]) begin
        int age = cyc - m_g[k];
        if (age == c_w[k] + 1 && !m_wr[k]) m_rd[k] = data_bus_read;
        if (age == c_w[k] + 2) m_act[k] = 1'b0;
      end else if (req0 || req1) begin
        bit own = (req0 && req1) ? !m_last[k] : req1;
        m_own[k]  = own;
        m_last[k] = own;
        m_g[k]    = cyc;
        m_act[k]  = 1'b1;
        m_addr[k] = own ? addr1  : addr0;
        m_dbw[k]  = own ? wdata1 : wdata0;
        m_wr[k]   = own ? wr_rd1 : wr_rd0;
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int age = cyc - m_g[k];
      bit e_cs  = m_act[k] && (age <= c_w[k]);
      bit e_ack = m_act[k] && (age == c_w[k] + 1);
      string p = $sformatf("w%0d", c_w[k]);
      chk({p, " cs"},    32'(cs_o[k]),   32'(e_cs));
      chk({p, " ack0"},  32'(ack0_o[k]), 32'(e_ack && !m_own[k]));
      chk({p, " ack1"},  32'(ack1_o[k]), 32'(e_ack && m_own[k]));
      chk({p, " addr"},  addr_o[k],      m_addr[k]);
      chk({p, " dbw"},   dbw_o[k],       m_dbw[k]);
      chk({p, " wr_rd"}, 32'(wr_o[k]),   32'(m_wr[k]));
      chk({p, " rdata"}, rdata_o[k],     m_rd[k]);
      chk({p, " ack overlap"}, 32'(ack0_o[k] & ack1_o[k]), 32'd0);
    end
  endtask

  // One clock: model follows the edge, outputs checked 1 ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst) m_edge();
    #1;
    compare_all();
  endtask

  task automatic set_idle_inputs();
    req0 = 0; req1 = 0; wr_rd0 = 0; wr_rd1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; data_bus_read = 0;
  endtask

  // Asynchronous reset applied mid-cycle, checked immediately, held 2 edges.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    m_reset();
    chk("async rst cs",   32'(cs_o),   32'd0);
    chk("async rst ack",  32'({ack0_o, ack1_o}), 32'd0);
    chk("async rst addr", addr_o[0] | addr_o[1], 32'd0);
    compare_all();
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          r0, r1, w1;
    logic [31:0] a0, a1, d1, dbr;
    bit          e_cs, e_ack0, e_ack1, e_wr;
    logic [31:0] e_addr, e_dbw, e_rdata;
  } vec_t;

  vec_t vt [10];
  int   ack_cyc [$];
  bit   ack_who [$];

  initial begin
    set_idle_inputs();
    rst = 1'b1;

    // Single read then single write on the WAIT_CYCLES=2 instance.
    //           r0 r1 w1  a0          a1          d1            dbr          cs a0 a1 wr addr        dbw           rdata
    vt[0] = '{1, 0, 0, 32'h100, 32'h0,   32'h0,        32'hCAFEF00D, 1, 0, 0, 0, 32'h100, 32'h0,        32'h0};
    vt[1] = '{0, 0, 0, 32'h100, 32'h0,   32'h0,        32'hCAFEF00D, 1, 0, 0, 0, 32'h100, 32'h0,        32'h0};
    vt[2] = '{0, 0, 0, 32'h100, 32'h0,   32'h0,        32'hCAFEF00D, 1, 0, 0, 0, 32'h100, 32'h0,        32'h0};
    vt[3] = '{0, 0, 0, 32'h100, 32'h0,   32'h0,        32'hCAFEF00D, 0, 1, 0, 0, 32'h100, 32'h0,        32'hCAFEF00D};
    vt[4] = '{0, 0, 0, 32'h100, 32'h0,   32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 32'h100, 32'h0,        32'hCAFEF00D};
    vt[5] = '{0, 1, 1, 32'h100, 32'h204, 32'h12345678, 32'hDEADBEEF, 1, 0, 0, 1, 32'h204, 32'h12345678, 32'hCAFEF00D};
    vt[6] = '{0, 0, 1, 32'h100, 32'h204, 32'h12345678, 32'hDEADBEEF, 1, 0, 0, 1, 32'h204, 32'h12345678, 32'hCAFEF00D};
    vt[7] = '{0, 0, 1, 32'h100, 32'h204, 32'h12345678, 32'hDEADBEEF, 1, 0, 0, 1, 32'h204, 32'h12345678, 32'hCAFEF00D};
    vt[8] = '{0, 0, 1, 32'h100, 32'h204, 32'h12345678, 32'hDEADBEEF, 0, 0, 1, 1, 32'h204, 32'h12345678, 32'hCAFEF00D};
    vt[9] = '{0, 0, 1, 32'h100, 32'h204, 32'h12345678, 32'hDEADBEEF, 0, 0, 0, 1, 32'h204, 32'h12345678, 32'hCAFEF00D};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; wr_rd0 = 1'b0; wr_rd1 = vt[i].w1;
      addr0 = vt[i].a0; addr1 = vt[i].a1; wdata1 = vt[i].d1;
      data_bus_read = vt[i].dbr;
      step();
      chk($sformatf("vec%0d cs", i),    32'(cs_o[0]),   32'(vt[i].e_cs));
      chk($sformatf("vec%0d ack0", i),  32'(ack0_o[0]), 32'(vt[i].e_ack0));
      chk($sformatf("vec%0d ack1", i),  32'(ack1_o[0]), 32'(vt[i].e_ack1));
      chk($sformatf("vec%0d wr_rd", i), 32'(wr_o[0]),   32'(vt[i].e_wr));
      chk($sformatf("vec%0d addr", i),  addr_o[0],      vt[i].e_addr);
      chk($sformatf("vec%0d dbw", i),   dbw_o[0],       vt[i].e_dbw);
      chk($sformatf("vec%0d rdata", i), rdata_o[0],     vt[i].e_rdata);
    end

    // Reset in the 2nd ACCESS cycle, then requester 1 re-arbitrated.
    set_idle_inputs();
    req0 = 1; addr0 = 32'h300; data_bus_read = 32'h77;
    step();
    req0 = 0;
    step();
    chk("midrst pre cs", 32'(cs_o[0]), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    m_reset();
    chk("midrst cs",   32'(cs_o[0]), 32'd0);
    chk("midrst addr", addr_o[0],    32'd0);
    chk("midrst ack",  32'({ack0_o[0], ack1_o[0]}), 32'd0);
    req1 = 1; addr1 = 32'h404; wr_rd1 = 0;
    step();
    rst = 1'b0;
    step();
    chk("rearb cs",   32'(cs_o[0]), 32'd1);
    chk("rearb addr", addr_o[0],    32'h404);
    req1 = 0;
    step(); step(); step();
    chk("rearb ack1", 32'(ack1_o[0]), 32'd1);
    chk("rearb ack0", 32'(ack0_o[0]), 32'd0);
    step();

    // WAIT_CYCLES=0 single read, with a mid-access input change on the W=2 unit.
    set_idle_inputs();
    do_reset();
    req0 = 1; addr0 = 32'h500; data_bus_read = 32'h55;
    step();
    chk("w0 cs on",   32'(cs_o[1]), 32'd1);
    req0 = 0; addr0 = 32'h999;
    step();
    chk("w0 cs off",  32'(cs_o[1]),   32'd0);
    chk("w0 ack0",    32'(ack0_o[1]), 32'd1);
    chk("w0 rdata",   rdata_o[1],     32'h55);
    chk("chg addr",   addr_o[0],      32'h500);
    step();
    chk("w0 ack0 end", 32'(ack0_o[1]), 32'd0);
    chk("chg cs",      32'(cs_o[0]),   32'd1);
    step();
    chk("chg ack0",   32'(ack0_o[0]), 32'd1);
    chk("chg addr2",  addr_o[0],      32'h500);
    step();

    // Contention from reset release: grants alternate 0,1,0,1 every 5 cycles.
    set_idle_inputs();
    req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      step();
      if (ack0_o[0] || ack1_o[0]) begin
        ack_cyc.push_back(cyc);
        ack_who.push_back(ack1_o[0]);
      end
    end
    chk("contend ack count", 32'(ack_cyc.size() >= 4), 32'd1);
    if (ack_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("contend order %0d", i), 32'(ack_who[i]), 32'(i % 2));
        if (i > 0) chk($sformatf("contend gap %0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
      end
    end

    // Randomized traffic with occasional asynchronous resets.
    set_idle_inputs();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      req0   = ($urandom_range(0, 2) != 0);
      req1   = ($urandom_range(0, 2) != 0);
      wr_rd0 = $urandom_range(0, 1) == 1;
      wr_rd1 = $urandom_range(0, 1) == 1;
      addr0  = $urandom; addr1  = $urandom;
      wdata0 = $urandom; wdata1 = $urandom;
      data_bus_read = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the extra bus cycles each access holds cs beyond the first; legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1, meaning the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning the reset: asynchronous and active-high.
REQ-004 The block SHALL have ports req0/req1, input, 1 each, meaning a requester asks for one bus access.
REQ-005 The block SHALL have ports addr0/addr1, input, 32 each, meaning the access address.
REQ-006 The block SHALL have ports wdata0/wdata1, input, 32 each, meaning the write data.
REQ-007 The block SHALL have ports wr_rd0/wr_rd1, input, 1 each, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have ports ack0/ack1, output, 1 each, meaning a one-cycle completion pulse to the owning requester.
REQ-009 The block SHALL have port rdata, output, 32, meaning the read data from the last completed read.
REQ-010 The block SHALL have port data_bus_read, input, 32, meaning the external bus read data.
REQ-011 The block SHALL have port addr, output, 32, meaning the external bus address.
REQ-012 The block SHALL have port data_bus_write, output, 32, meaning the external bus write data.
REQ-013 The block SHALL have port cs, output, 1, meaning external chip select, active-high.
REQ-014 The block SHALL have port wr_rd, output, 1, meaning the external direction, 1 = write.

Function
REQ-015 The block SHALL implement states IDLE, ACCESS and DONE, with all outputs registered (Moore).
REQ-016 In IDLE with any req high at an edge, the block SHALL grant exactly one requester, latch its addr, wdata and wr_rd onto addr, data_bus_write and wr_rd, load a counter with WAIT_CYCLES, and enter ACCESS.
REQ-017 Arbitration SHALL be round-robin: a lone requester wins; if both are high, the requester not granted last time wins; the last-grant pointer updates on each grant.
REQ-018 In ACCESS, cs SHALL be 1 and addr, data_bus_write and wr_rd SHALL stay constant.
REQ-019 At each ACCESS edge, the block SHALL decrement the counter if it is nonzero; if it is zero, the block SHALL enter DONE and, for a read, capture data_bus_read into rdata.
REQ-020 ACCESS SHALL therefore last exactly WAIT_CYCLES+1 cycles.
REQ-021 In DONE, cs SHALL be 0, the owner's ack SHALL be 1 for exactly one cycle, the other ack SHALL be 0, and the next state SHALL be IDLE.
REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL leave rdata unchanged.
REQ-023 Latency SHALL be: req sampled at edge N, cs high in cycles N+1..N+1+WAIT_CYCLES, ack high in cycle N+2+WAIT_CYCLES.
REQ-024 Once granted, an access SHALL complete even if req drops or its inputs change; the latched values SHALL be used.
REQ-025 A req still high in IDLE after DONE SHALL be treated as a new request, so back-to-back accesses are separated by exactly one IDLE cycle.
REQ-026 In IDLE and DONE, addr, data_bus_write and wr_rd SHALL hold their last values, and cs SHALL be 0.
REQ-027 ack0 and ack1 SHALL never be high simultaneously, and cs SHALL never be high outside ACCESS.

Reset
REQ-028 While rst is high, the block SHALL asynchronously force: state IDLE, cs 0, wr_rd 0, addr 0, data_bus_write 0, ack0 0, ack1 0, rdata 0, counter 0, last-grant = requester 1 (so requester 0 wins the first tie).
REQ-029 A reset asserted mid-ACCESS SHALL abort the access with no ack and no rdata update; after release, any pending req SHALL be re-arbitrated from IDLE.

Verification
REQ-030 Single read (WAIT_CYCLES=2): req0=1, addr0=0x100, wr_rd0=0, data_bus_read=0xCAFEF00D -> cs high 3 cycles with addr=0x100 and wr_rd=0, then ack0 pulses 1 cycle, rdata=0xCAFEF00D.
REQ-031 Single write: req1=1, addr1=0x204, wdata1=0x12345678, wr_rd1=1 -> cs high 3 cycles with wr_rd=1 and data_bus_write=0x12345678, then ack1 pulses, rdata unchanged.
REQ-032 Contention: req0 and req1 held high from reset release -> grant order 0,1,0,1, one IDLE cycle between accesses, acks alternating and never overlapping.
REQ-033 WAIT_CYCLES=0: lone req0 read -> cs high exactly 1 cycle, ack0 in the following cycle.
REQ-034 Mid-access input change: req0 drops and addr0 changes during ACCESS -> bus addr unchanged, access completes, ack0 still pulses.
REQ-035 Reset mid-access: rst pulsed in the 2nd ACCESS cycle -> cs, addr and acks go to 0 immediately, no ack; with req1 high after release, requester 1 is granted from IDLE.
